// File: rtl/sprite_pkg.sv
// Shared sprite definitions for the blitter and compositor.
// The mirror field exists only when SPRITE_MIRROR_EN is defined.
package sprite_pkg;

  localparam int unsigned COORD_W = 10;
  localparam int unsigned IDX_W   = 4;

  localparam logic [IDX_W-1:0] TRANSP_IDX_DEF = '0;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
`ifdef SPRITE_MIRROR_EN
    logic               mirror;
`endif
  } sprite_pos_t;

endpackage

// File: rtl/sprite_addr_gen.sv
// Combinational box test, integer downscale, optional X mirror and ROM address sum.
// Mirroring is compiled in only when SPRITE_MIRROR_EN is defined.
module sprite_addr_gen
  import sprite_pkg::*;
#(
  parameter int unsigned SPR_W      = 64,
  parameter int unsigned SPR_H      = 64,
  parameter int unsigned SCALE_LOG2 = 0,
  parameter int unsigned FRM_W      = 2,
  parameter int unsigned ADDR_W     = 14
) (
  input  logic [COORD_W-1:0] draw_x,
  input  logic [COORD_W-1:0] draw_y,
  input  sprite_pos_t        act_pos,
  input  logic [FRM_W-1:0]   frame,
  output logic               inbox_c,
  output logic [ADDR_W-1:0]  addr_c
);

  localparam int unsigned LX_W  = $clog2(SPR_W);
  localparam int unsigned LY_W  = $clog2(SPR_H);
  localparam int unsigned EXT_W = COORD_W + 1;

  localparam logic [EXT_W-1:0] BOX_W = EXT_W'(SPR_W << SCALE_LOG2);
  localparam logic [EXT_W-1:0] BOX_H = EXT_W'(SPR_H << SCALE_LOG2);

  logic [EXT_W-1:0] dx;
  logic [EXT_W-1:0] dy;
  logic             in_x;
  logic             in_y;
  logic [LX_W-1:0]  lx;
  logic [LY_W-1:0]  ly;

  // Power-of-two sprite dimensions let the address be a plain concatenation.
  always_comb begin
    dx      = {1'b0, draw_x} - {1'b0, act_pos.x};
    dy      = {1'b0, draw_y} - {1'b0, act_pos.y};
    in_x    = (draw_x >= act_pos.x) && (dx < BOX_W);
    in_y    = (draw_y >= act_pos.y) && (dy < BOX_H);
    inbox_c = in_x && in_y;
    lx      = LX_W'(dx >> SCALE_LOG2);
    ly      = LY_W'(dy >> SCALE_LOG2);
`ifdef SPRITE_MIRROR_EN
    if (act_pos.mirror) begin
      lx = ~lx;
    end
`endif
    if (!inbox_c) begin
      lx = '0;
      ly = '0;
    end
    addr_c = ADDR_W'({frame, ly, lx});
  end

endmodule

// File: rtl/sprite_blitter.sv
// Single-sprite renderer: position handshake, animation counters and two-stage ROM pipeline.
// Define SPRITE_MIRROR_EN to add the mirror_x input and horizontal mirroring.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int unsigned      SPR_W      = 64,
  parameter int unsigned      SPR_H      = 64,
  parameter int unsigned      FRAMES     = 4,
  parameter int unsigned      SCALE_LOG2 = 0,
  parameter int unsigned      FRAME_HOLD = 8,
  parameter logic [IDX_W-1:0] TRANSP_IDX = TRANSP_IDX_DEF,
  parameter int unsigned      ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES)
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  input  logic [COORD_W-1:0] DrawX,
  input  logic [COORD_W-1:0] DrawY,
  input  logic               blank,
  input  logic               frame_start,
  input  logic               pos_valid,
  output logic               pos_ready,
  input  logic [COORD_W-1:0] pos_x,
  input  logic [COORD_W-1:0] pos_y,
`ifdef SPRITE_MIRROR_EN
  input  logic               mirror_x,
`endif
  input  logic               anim_en,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [IDX_W-1:0]   rom_q,
  output logic               sprite_hit,
  output logic [IDX_W-1:0]   sprite_idx
);

  localparam int unsigned FRM_W  = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam int unsigned HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

  localparam logic [FRM_W-1:0]  FRAME_LAST = FRM_W'(FRAMES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);

  sprite_pos_t       shadow_pos;
  sprite_pos_t       act_pos;
  sprite_pos_t       new_pos;
  logic              pending;
  logic              accept;
  logic [FRM_W-1:0]  frame;
  logic [HOLD_W-1:0] hold;
  logic              inbox_c;
  logic [ADDR_W-1:0] addr_c;
  logic              inbox_d;
  logic              blank_d;
  logic              opaque_c;

  always_comb begin
    new_pos   = '0;
    new_pos.x = pos_x;
    new_pos.y = pos_y;
`ifdef SPRITE_MIRROR_EN
    new_pos.mirror = mirror_x;
`endif
    accept   = pos_valid && pos_ready;
    opaque_c = inbox_d && blank_d && (rom_q != TRANSP_IDX);
  end

  // Shadow/active position: updates are only applied on frame_start to avoid tearing.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_pos <= '0;
      act_pos    <= '0;
      pending    <= 1'b0;
      pos_ready  <= 1'b1;
    end else begin
      if (frame_start && pending) begin
        act_pos   <= shadow_pos;
        pending   <= 1'b0;
        pos_ready <= 1'b1;
      end
      if (accept) begin
        shadow_pos <= new_pos;
        pending    <= 1'b1;
        pos_ready  <= 1'b0;
      end
    end
  end

  // Animation: hold counter paces the frame index; anim_en low freezes both.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame <= '0;
      hold  <= '0;
    end else if (frame_start && anim_en) begin
      if (hold == HOLD_LAST) begin
        hold  <= '0;
        frame <= (frame == FRAME_LAST) ? '0 : frame + FRM_W'(1);
      end else begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

  sprite_addr_gen #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .SCALE_LOG2 (SCALE_LOG2),
    .FRM_W      (FRM_W),
    .ADDR_W     (ADDR_W)
  ) u_addr_gen (
    .draw_x  (DrawX),
    .draw_y  (DrawY),
    .act_pos (act_pos),
    .frame   (frame),
    .inbox_c (inbox_c),
    .addr_c  (addr_c)
  );

  // Stage 1 issues the ROM read; stage 2 qualifies the returned texel.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      inbox_d     <= 1'b0;
      blank_d     <= 1'b0;
      sprite_hit  <= 1'b0;
      sprite_idx  <= '0;
    end else begin
      rom_address <= addr_c;
      inbox_d     <= inbox_c;
      blank_d     <= blank;
      sprite_hit  <= opaque_c;
      sprite_idx  <= opaque_c ? rom_q : '0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// Scoreboard bench for sprite_blitter (64x64, 4 frames, 2x scale, FRAME_HOLD=2).
// Define SPRITE_MIRROR_EN to also cover the mirror_x path.
module tb_sprite_blitter;
  import sprite_pkg::*;

  localparam int unsigned AW = 14;

  logic               vga_clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [COORD_W-1:0] DrawX = '0;
  logic [COORD_W-1:0] DrawY = '0;
  logic               blank = 1'b0;
  logic               frame_start = 1'b0;
  logic               pos_valid = 1'b0;
  logic               pos_ready;
  logic [COORD_W-1:0] pos_x = '0;
  logic [COORD_W-1:0] pos_y = '0;
`ifdef SPRITE_MIRROR_EN
  logic               mirror_x = 1'b0;
`endif
  logic               anim_en = 1'b0;
  logic [AW-1:0]      rom_address;
  logic [IDX_W-1:0]   rom_q = '0;
  logic               sprite_hit;
  logic [IDX_W-1:0]   sprite_idx;

  always #5 vga_clk = ~vga_clk;

  sprite_blitter #(
    .SPR_W      (64),
    .SPR_H      (64),
    .FRAMES     (4),
    .SCALE_LOG2 (1),
    .FRAME_HOLD (2),
    .TRANSP_IDX (4'd0)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .frame_start (frame_start),
    .pos_valid   (pos_valid),
    .pos_ready   (pos_ready),
    .pos_x       (pos_x),
    .pos_y       (pos_y),
`ifdef SPRITE_MIRROR_EN
    .mirror_x    (mirror_x),
`endif
    .anim_en     (anim_en),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .sprite_hit  (sprite_hit),
    .sprite_idx  (sprite_idx)
  );

  // kind: 0 rom_address, 1 sprite_hit, 2 sprite_idx, 3 pos_ready
  typedef struct {
    string       name;
    int          due;
    int          kind;
    int unsigned exp;
  } chk_t;

  chk_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic logic [31:0] actual(input int kind);
    case (kind)
      0:       return 32'(rom_address);
      1:       return 32'(sprite_hit);
      2:       return 32'(sprite_idx);
      default: return 32'(pos_ready);
    endcase
  endfunction

  // Monitor: pops every expectation whose output slot is the current cycle.
  always @(negedge vga_clk) begin
    chk_t        c;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      c   = sb.pop_front();
      act = actual(c.kind);
      n_checks++;
      if (c.due < cyc) begin
        n_fail++;
        $display("FAIL %s: output slot missed (due cycle %0d, now %0d)", c.name, c.due, cyc);
      end else if (act !== 32'(c.exp)) begin
        n_fail++;
        $display("FAIL %s: got %0d, expected %0d", c.name, act, c.exp);
      end
    end
  end

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic expect_now(input int kind, input int unsigned exp, input string name);
    sb.push_back('{name, cyc, kind, exp});
  endtask

  // One pixel through the pipe: address after edge 1, hit/idx after edge 2.
  task automatic pix(input int x, input int y, input logic b, input int q,
                     input int unsigned e_addr, input int unsigned e_hit,
                     input int unsigned e_idx, input string name);
    DrawX = COORD_W'(x);
    DrawY = COORD_W'(y);
    blank = b;
    sb.push_back('{{name, ".addr"}, cyc + 1, 0, e_addr});
    sb.push_back('{{name, ".hit"},  cyc + 2, 1, e_hit});
    sb.push_back('{{name, ".idx"},  cyc + 2, 2, e_idx});
    tick();
    rom_q = IDX_W'(q);
    tick();
  endtask

  task automatic send_pos(input int x, input int y);
    pos_x     = COORD_W'(x);
    pos_y     = COORD_W'(y);
    pos_valid = 1'b1;
    for (int i = 0; i < 50 && !pos_ready; i++) tick();
    if (!pos_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_pos: pos_ready stayed low for 50 cycles");
    end else begin
      tick();
    end
    pos_valid = 1'b0;
  endtask

  task automatic fstart();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    int fr [8];
    fr = '{0, 1, 1, 2, 2, 3, 3, 0};

    // Reset state
    tick();
    tick();
    expect_now(0, 0, "rst.addr");
    expect_now(1, 0, "rst.hit");
    expect_now(2, 0, "rst.idx");
    expect_now(3, 1, "rst.ready");
    tick();
    reset_n = 1'b1;
    tick();

    // First placement at (100,50)
    send_pos(100, 50);
    expect_now(3, 0, "accept.ready_low");
    fstart();
    expect_now(3, 1, "apply.ready_high");
    pix(100, 50, 1'b1, 5, 0, 1, 5, "origin");
    pix(101, 50, 1'b1, 0, 0, 0, 0, "transparent");
    pix(103, 51, 1'b0, 7, 1, 0, 0, "blanked");
    pix(99, 50, 1'b1, 7, 0, 0, 0, "left_of_box");
    pix(227, 177, 1'b1, 9, 4095, 1, 9, "far_corner");
    pix(228, 50, 1'b1, 9, 0, 0, 0, "right_of_box");

    // Mid-frame move is shadowed until frame_start; second offer stalls
    send_pos(200, 10);
    expect_now(3, 0, "move.ready_low");
    pos_x     = 10'd300;
    pos_valid = 1'b1;
    tick();
    tick();
    expect_now(3, 0, "stall.ready_low");
    pos_valid = 1'b0;
    pix(100, 50, 1'b1, 5, 0, 1, 5, "old_pos_still");
    pix(200, 10, 1'b1, 5, 0, 0, 0, "new_pos_early");
    fstart();
    expect_now(3, 1, "move.ready_high");
    pix(200, 10, 1'b1, 6, 0, 1, 6, "new_pos_applied");
    pix(100, 50, 1'b1, 6, 0, 0, 0, "old_pos_gone");

    // Animation: FRAME_HOLD=2 over 8 frame_starts
    anim_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      fstart();
      pix(202, 10, 1'b1, 1, 32'(fr[i]) * 4096 + 1, 1, 1, $sformatf("anim%0d", i));
    end
    fstart();
    anim_en = 1'b0;
    for (int i = 0; i < 3; i++) fstart();
    pix(202, 10, 1'b1, 1, 1, 1, 1, "anim_frozen");
    anim_en = 1'b1;
    fstart();
    anim_en = 1'b0;
    pix(202, 10, 1'b1, 1, 4097, 1, 1, "anim_hold_kept");

    // Scaled box edges and right-edge placement (frame 1 now)
    send_pos(0, 0);
    fstart();
    pix(127, 127, 1'b1, 3, 8191, 1, 3, "scale_corner");
    pix(128, 127, 1'b1, 3, 4096, 0, 0, "scale_outside");
    send_pos(620, 0);
    fstart();
    pix(639, 0, 1'b1, 2, 4105, 1, 2, "right_edge_hit");
    pix(0, 0, 1'b1, 2, 4096, 0, 0, "no_wrap");

    // Accept coinciding with frame_start while nothing pending
    pos_x       = 10'd10;
    pos_y       = 10'd10;
    pos_valid   = 1'b1;
    frame_start = 1'b1;
    tick();
    pos_valid   = 1'b0;
    frame_start = 1'b0;
    expect_now(3, 0, "coincide.ready_low");
    pix(10, 10, 1'b1, 4, 4096, 0, 0, "coincide_not_yet");
    fstart();
    expect_now(3, 1, "coincide.ready_high");
    pix(10, 10, 1'b1, 4, 4096, 1, 4, "coincide_applied");

`ifdef SPRITE_MIRROR_EN
    mirror_x = 1'b1;
    send_pos(10, 10);
    mirror_x = 1'b0;
    fstart();
    pix(10, 10, 1'b1, 1, 4096 + 63, 1, 1, "mirror_lx63");
`endif

    // Reset mid-line with a pending shadow
    send_pos(50, 50);
    DrawX = 10'd60;
    DrawY = 10'd60;
    tick();
    reset_n = 1'b0;
    expect_now(0, 0, "midrst.addr");
    expect_now(1, 0, "midrst.hit");
    expect_now(2, 0, "midrst.idx");
    expect_now(3, 1, "midrst.ready");
    tick();
    reset_n = 1'b1;
    tick();
    fstart();
    pix(10, 10, 1'b1, 4, 325, 1, 4, "post_rst_pending_dropped");

    tick();
    tick();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised single-sprite renderer for the VGA path. It takes the current scan position and returns a registered per-pixel hit flag and a 4-bit palette index for one sprite. The sprite is placed at a runtime position loaded by handshake and is integer-scaled and animated across multiple frames stored in one external synchronous ROM. It sits between the VGA controller and the compositor/palette stage, replacing per-asset full-screen stretch examples.

## Interface
- SPR_W, 64, sprite width in texels (power of two)
- SPR_H, 64, sprite height in texels (power of two)
- FRAMES, 4, animation frames stored back-to-back in ROM
- SCALE_LOG2, 0, integer upscale of 2^SCALE_LOG2 (0..3)
- FRAME_HOLD, 8, screen frames per animation frame (≥1)
- TRANSP_IDX, 0, palette index treated as transparent
- ADDR_W, $clog2(SPR_W*SPR_H*FRAMES), ROM address width (derived)
- vga_clk  in  1  pixel clock, all state on posedge
- reset_n  in  1  asynchronous, active-low reset
- DrawX, DrawY  in  10 each  current scan coordinate
- blank  in  1  high = visible region
- frame_start  in  1  one-cycle pulse at start of vertical blank
- pos_valid  in  1  new position offered
- pos_ready  out  1  shadow register free
- pos_x, pos_y  in  10 each  sprite top-left, screen pixels
- anim_en  in  1  animation advance enable
- rom_address  out  ADDR_W  registered ROM address
- rom_q  in  4  ROM data, valid one cycle after rom_address
- sprite_hit  out  1  opaque sprite pixel at this output slot
- sprite_idx  out  4  palette index (0 when sprite_hit=0)

## Operation
- Position: transfer when pos_valid&&pos_ready → shadow loaded, pending=1, pos_ready=0. At frame_start with pending=1: active←shadow, pending←0. Same-cycle accept and frame_start with pending=0: shadow loads, applied at the *next* frame_start. No mid-frame tearing.
- Animation: on frame_start with anim_en=1, hold counter increments. At FRAME_HOLD-1 it wraps to 0 and frame index increments mod FRAMES. anim_en=0 freezes both counters and does not clear them.
- Addressing (11-bit unsigned math, no wrap): dx=DrawX-act_x, dy=DrawY-act_y. inbox = DrawX≥act_x && dx<(SPR_W<<SCALE_LOG2), and likewise for Y. lx=dx>>SCALE_LOG2, ly=dy>>SCALE_LOG2. Address = frame*SPR_W*SPR_H + ly*SPR_W + lx. Out of box, address = frame base.
- Output: sprite_hit = inbox_d && blank_d && rom_q≠TRANSP_IDX. sprite_idx = rom_q when hit, else 0.
- Reset values: pos_ready=1, pending=0, active/shadow pos 0, frame=0, hold=0, rom_address=0, sprite_hit=0, sprite_idx=0. A reset mid-frame takes effect immediately and drops any pending shadow.

## Timing
- Stage 1 (edge 1): rom_address, inbox_d and blank_d are registered from DrawX/DrawY.
- Stage 2 (edge 2): sprite_hit and sprite_idx are registered from rom_q. Total latency is 2 vga_clk edges from DrawX/DrawY to output. The compositor delays its own DrawX by 2.
- pos_ready falls on the edge after acceptance and rises on the edge after the applying frame_start.
- Frame index changes only on a frame_start edge. It is constant for the whole visible frame.

## Configuration
- SPRITE_MIRROR_EN defined: adds input mirror_x (1 bit), captured into the shadow with pos_x/pos_y and applied at frame_start; when active, lx is replaced by SPR_W-1-lx. Reset value 0.
- SPRITE_MIRROR_EN undefined: no mirror_x port, no mirroring logic.

## Structure
- Shared package sprite_pkg holds the following, used by the compositor too:
  - coordinate width (10)
  - the palette-index width (4)
  - a struct sprite_pos_t {x, y[, mirror]}
  - the TRANSP_IDX default
- One sub-module, sprite_addr_gen: the combinational box test, scaling shift, optional mirror and address sum. The parent holds the handshake, the animation counters and both pipeline stages.

## Test plan
- Reset, then pos (100,50) accepted and frame_start pulsed. DrawX=100, DrawY=50 → rom_address=0 after 1 edge; rom_q=5 → sprite_hit=1, sprite_idx=5 after edge 2.
- rom_q=TRANSP_IDX, or blank=0, inside box → sprite_hit=0, sprite_idx=0.
- Accept pos (200,10) mid-frame → pos_ready=0. A second pos_valid stalls. Pixels at (100,50) still hit until frame_start, after which (200,10) maps to address 0.
- FRAME_HOLD=2, FRAMES=4, anim_en=1, 8 frame_starts → frame sequence 0,0,1,1,2,2,3,3, then wraps to 0; base address 4096*frame. anim_en=0 holds the frame.
- SCALE_LOG2=1, pos (0,0): DrawX=DrawY=127 → address 4095; DrawX=128 → no hit. pos_x=620: DrawX=639 hits, DrawX=0 does not.
- With SPRITE_MIRROR_EN defined and mirror_x=1: DrawX=pos_x → lx=63. Assert reset_n=0 mid-line → all outputs 0 on the next cycle.
